// File: rtl/sobol_pkg.sv
// rtl/sobol_pkg.sv - shared types and constants for the Sobol sequencer
package sobol_pkg;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_GAP  = 2'd2,
    S_EMIT = 2'd3
  } state_t;

  localparam int SOBOL_W = 6;
  localparam int IDX_W   = 6;
  localparam int NUM_M   = 6;

  // Direction number m<k> (k = 1..6) occupies [m_lo(k) +: SOBOL_W] of a packed m word.
  function automatic int m_lo(input int k);
    return (k - 1) * SOBOL_W;
  endfunction

endpackage

// File: rtl/sobol_cfg_regfile.sv
// rtl/sobol_cfg_regfile.sv - per-dimension direction-number storage
// Writes are dropped while locked; a same-cycle write is forwarded to the read port.
module sobol_cfg_regfile
  import sobol_pkg::*;
#(
  parameter int NDIM = 4,
  parameter int W    = SOBOL_W
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      lock,
  input  logic                      we,
  input  logic [$clog2(NDIM)-1:0]   waddr,
  input  logic [NUM_M*W-1:0]        wdata,
  input  logic [$clog2(NDIM)-1:0]   raddr,
  output logic [NUM_M*W-1:0]        rdata
);

  logic [NUM_M*W-1:0] m_reg [NDIM];
  logic               wr;

  assign wr = we && !lock && (int'(waddr) < NDIM);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < NDIM; i++) m_reg[i] <= '0;
    end else if (wr) begin
      m_reg[waddr] <= wdata;
    end
  end

  // Forwarding lets a start issued with a config write run on the new value.
  assign rdata = (wr && waddr == raddr) ? wdata : m_reg[raddr];

endmodule

// File: rtl/sobol_seq_ctrl.sv
// rtl/sobol_seq_ctrl.sv - time-shares one Sobol step datapath across NDIM dimensions
// Walks dims per point index, captures each result, emits the assembled point.
module sobol_seq_ctrl
  import sobol_pkg::*;
#(
  parameter int NDIM    = 4,
  parameter int W       = SOBOL_W,
  parameter int TIMEOUT = 255
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     start,
  input  logic                     abort,
  input  logic [IDX_W-1:0]         num_pts,
  input  logic                     cfg_we,
  input  logic [$clog2(NDIM)-1:0]  cfg_dim,
  input  logic [NUM_M*W-1:0]       cfg_m,
  output logic                     unit_en,
  output logic [NUM_M*W-1:0]       unit_m,
  output logic [IDX_W-1:0]         unit_count,
  output logic [W-1:0]             unit_xprev,
  input  logic                     unit_valid,
  input  logic [W-1:0]             unit_x,
  output logic                     pt_valid,
  input  logic                     pt_ready,
  output logic [NDIM*W-1:0]        pt_data,
  output logic [IDX_W-1:0]         pt_index,
  output logic                     busy,
  output logic                     done,
  output logic                     err
);

  localparam int DW = $clog2(NDIM);
  localparam int TW = $clog2(TIMEOUT + 1);

  state_t           state, state_n;
  logic [IDX_W-1:0] idx, idx_n, npts, npts_n;
  logic [DW-1:0]    dim, dim_n;
  logic [TW-1:0]    wd, wd_n;
  logic [W-1:0]     x_reg [NDIM];
  logic             err_n, done_n, capture;
  logic [NUM_M*W-1:0] m_rd;

  sobol_cfg_regfile #(.NDIM(NDIM), .W(W)) u_cfg (
    .clk   (clk),
    .rst   (rst),
    .lock  (busy),
    .we    (cfg_we),
    .waddr (cfg_dim),
    .wdata (cfg_m),
    .raddr (dim_n),
    .rdata (m_rd)
  );

  always_comb begin
    state_n = state;
    idx_n   = idx;
    dim_n   = dim;
    npts_n  = npts;
    wd_n    = wd;
    err_n   = err;
    done_n  = 1'b0;
    capture = 1'b0;
    case (state)
      S_IDLE: begin
        if (start) begin
          err_n = 1'b0;
          if (num_pts == '0) begin
            done_n = 1'b1;
          end else begin
            npts_n  = num_pts;
            idx_n   = '0;
            dim_n   = '0;
            wd_n    = '0;
            state_n = S_RUN;
          end
        end
      end
      S_RUN: begin
        if (unit_valid) begin
          capture = 1'b1;
          state_n = S_GAP;
        end else if (wd == TW'(TIMEOUT - 1)) begin
          err_n   = 1'b1;
          done_n  = 1'b1;
          state_n = S_IDLE;
        end else begin
          wd_n = wd + TW'(1);
        end
      end
      S_GAP: begin
        wd_n = '0;
        if (dim == DW'(NDIM - 1)) begin
          state_n = S_EMIT;
        end else begin
          dim_n   = dim + DW'(1);
          state_n = S_RUN;
        end
      end
      S_EMIT: begin
        if (pt_ready) begin
          if (idx == npts - IDX_W'(1)) begin
            done_n  = 1'b1;
            state_n = S_IDLE;
          end else begin
            idx_n   = idx + IDX_W'(1);
            dim_n   = '0;
            wd_n    = '0;
            state_n = S_RUN;
          end
        end
      end
      default: state_n = S_IDLE;
    endcase
    // Abort overrides every same-cycle event: no capture, no done, no new error.
    if (abort && state != S_IDLE) begin
      state_n = S_IDLE;
      done_n  = 1'b0;
      capture = 1'b0;
      err_n   = err;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state      <= S_IDLE;
      idx        <= '0;
      dim        <= '0;
      npts       <= '0;
      wd         <= '0;
      for (int i = 0; i < NDIM; i++) x_reg[i] <= '0;
      unit_en    <= 1'b0;
      unit_m     <= '0;
      unit_count <= '0;
      unit_xprev <= '0;
      pt_valid   <= 1'b0;
      pt_data    <= '0;
      pt_index   <= '0;
      busy       <= 1'b0;
      done       <= 1'b0;
      err        <= 1'b0;
    end else begin
      state    <= state_n;
      idx      <= idx_n;
      dim      <= dim_n;
      npts     <= npts_n;
      wd       <= wd_n;
      err      <= err_n;
      done     <= done_n;
      busy     <= (state_n != S_IDLE);
      unit_en  <= (state_n == S_RUN);
      pt_valid <= (state_n == S_EMIT);
      if (state_n == S_RUN) begin
        unit_m     <= m_rd;
        unit_count <= idx_n;
        unit_xprev <= (idx_n == '0) ? '0 : x_reg[dim_n];
      end
      if (capture) begin
        x_reg[dim]         <= unit_x;
        pt_data[dim*W +: W] <= unit_x;
      end
      if (state_n == S_EMIT && state != S_EMIT) pt_index <= idx;
    end
  end

endmodule
